// File: rtl/pf_pkg.sv
// Shared encodings for the pooling address generator: op codes, control codes and FSM states.
package pf_pkg;

    localparam logic [1:0] AVG = 2'b00;
    localparam logic [1:0] MIN = 2'b01;
    localparam logic [1:0] MAX = 2'b10;

    localparam logic CYCLE       = 1'b0;
    localparam logic START_CYCLE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } pf_state_t;

endpackage

// File: rtl/pf_delay_line.sv
// Fixed-depth shift register that lines up issue-time control with the compute unit's registered input.
module pf_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_res,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_dout = r_stage[DEPTH-1];

endmodule

// File: rtl/pf_pool_addr_fsm.sv
// Window-order read address generator for the pooling unit.
// state | meaning: IDLE wait start | RUN one address/cycle | FLUSH dummy START + drain | DONE done pulse
module pf_pool_addr_fsm
    import pf_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int POOL   = 2,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic [1:0]        op_type_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              cntrl,
    output logic              din_valid,
    output logic [1:0]        op_type,
    output logic              busy,
    output logic              done
);

    localparam int OUT_W = IMG_W / POOL;
    localparam int OUT_H = IMG_H / POOL;
    localparam int KX_W  = $clog2(POOL + 1);
    localparam int OX_W  = $clog2(OUT_W + 1);
    localparam int OY_W  = $clog2(OUT_H + 1);
    localparam int FL_W  = $clog2(RD_LAT + 2);

    localparam logic [KX_W-1:0]   K_LAST    = KX_W'(POOL - 1);
    localparam logic [OX_W-1:0]   OX_LAST   = OX_W'(OUT_W - 1);
    localparam logic [OY_W-1:0]   OY_LAST   = OY_W'(OUT_H - 1);
    localparam logic [FL_W-1:0]   FL_INIT   = FL_W'(RD_LAT + 1);
    localparam logic [ADDR_W-1:0] STEP_ROW  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] STEP_WIN  = ADDR_W'(POOL);
    localparam logic [ADDR_W-1:0] STEP_WROW = ADDR_W'(IMG_W * (POOL - 1) + POOL);

    if ((IMG_W % POOL) != 0) begin : g_chk_w
        $error("IMG_W must be a multiple of POOL");
    end
    if ((IMG_H % POOL) != 0) begin : g_chk_h
        $error("IMG_H must be a multiple of POOL");
    end
    if ((1 << ADDR_W) < IMG_W * IMG_H) begin : g_chk_a
        $error("ADDR_W too small for the frame");
    end

    pf_state_t         r_state;
    logic [KX_W-1:0]   r_kx;
    logic [KX_W-1:0]   r_ky;
    logic [OX_W-1:0]   r_ox;
    logic [OY_W-1:0]   r_oy;
    logic [ADDR_W-1:0] r_row_off;
    logic [ADDR_W-1:0] r_win_base;
    logic [FL_W-1:0]   r_flush_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd_en;
    logic [1:0]        r_op_type;
    logic              r_busy;
    logic              r_done;

    logic [KX_W-1:0]   w_nxt_kx;
    logic [KX_W-1:0]   w_nxt_ky;
    logic [OX_W-1:0]   w_nxt_ox;
    logic [OY_W-1:0]   w_nxt_oy;
    logic [ADDR_W-1:0] w_nxt_row_off;
    logic [ADDR_W-1:0] w_nxt_base;
    logic [ADDR_W-1:0] w_nxt_addr;
    logic              w_frame_end;
    logic              w_raw_cntrl;
    logic              w_raw_valid;
    logic [1:0]        w_dly_out;

    // Nested counter advance: kx inside ky inside ox inside oy, base moved by additions only.
    always_comb begin
        w_nxt_kx      = r_kx + 1'b1;
        w_nxt_ky      = r_ky;
        w_nxt_ox      = r_ox;
        w_nxt_oy      = r_oy;
        w_nxt_row_off = r_row_off;
        w_nxt_base    = r_win_base;
        w_frame_end   = 1'b0;
        if (r_kx == K_LAST) begin
            w_nxt_kx = '0;
            if (r_ky != K_LAST) begin
                w_nxt_ky      = r_ky + 1'b1;
                w_nxt_row_off = r_row_off + STEP_ROW;
            end else begin
                w_nxt_ky      = '0;
                w_nxt_row_off = '0;
                if (r_ox != OX_LAST) begin
                    w_nxt_ox   = r_ox + 1'b1;
                    w_nxt_base = r_win_base + STEP_WIN;
                end else begin
                    w_nxt_ox   = '0;
                    w_nxt_base = r_win_base + STEP_WROW;
                    if (r_oy != OY_LAST) begin
                        w_nxt_oy = r_oy + 1'b1;
                    end else begin
                        w_nxt_oy    = '0;
                        w_nxt_base  = '0;
                        w_frame_end = 1'b1;
                    end
                end
            end
        end
        w_nxt_addr = w_nxt_base + w_nxt_row_off + ADDR_W'(w_nxt_kx);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state     <= IDLE;
            r_kx        <= '0;
            r_ky        <= '0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_row_off   <= '0;
            r_win_base  <= '0;
            r_flush_cnt <= '0;
            r_mem_addr  <= '0;
            r_mem_rd_en <= 1'b0;
            r_op_type   <= 2'b00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op_type   <= op_type_in;
                        r_state     <= RUN;
                        r_busy      <= 1'b1;
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= '0;
                    end
                end
                RUN: begin
                    r_kx       <= w_nxt_kx;
                    r_ky       <= w_nxt_ky;
                    r_ox       <= w_nxt_ox;
                    r_oy       <= w_nxt_oy;
                    r_row_off  <= w_nxt_row_off;
                    r_win_base <= w_nxt_base;
                    r_mem_addr <= w_nxt_addr;
                    if (w_frame_end) begin
                        r_state     <= FLUSH;
                        r_mem_rd_en <= 1'b0;
                        r_flush_cnt <= FL_INIT;
                    end
                end
                FLUSH: begin
                    if (r_flush_cnt == '0) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The first FLUSH cycle is a dummy START that pushes the last window out of the compute unit.
    assign w_raw_cntrl = (((r_state == RUN) && (r_kx == '0) && (r_ky == '0)) ||
                          ((r_state == FLUSH) && (r_flush_cnt == FL_INIT))) ? START_CYCLE : CYCLE;
    assign w_raw_valid = (r_state == RUN);

    pf_delay_line #(
        .WIDTH (2),
        .DEPTH (RD_LAT + 1)
    ) u_dly (
        .i_clk  (clk),
        .i_res  (res),
        .i_din  ({w_raw_cntrl, w_raw_valid}),
        .o_dout (w_dly_out)
    );

    assign mem_addr  = r_mem_addr;
    assign mem_rd_en = r_mem_rd_en;
    assign cntrl     = w_dly_out[1];
    assign din_valid = w_dly_out[0];
    assign op_type   = r_op_type;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
